sdram_burst_rd: RTL
===================

# sdram_burst_rd

Parametrised SDRAM read engine for the address-read test path. On a debounced button falling edge, or a `iSTART` pulse, it captures a start address and word count. It then issues Avalon-MM-style single-word reads with `waitrequest` back-pressure, keeps up to `MAX_OUTST` reads pipelined, and streams every returned word out with a valid strobe. It replaces the fixed single-word read tester and sits between the front-panel and debug logic and the SDRAM controller's read port.

## Interface
Parameters:
- `ADDR_W`, 25, address width in words.
- `DATA_W`, 16, data width.
- `LEN_W`, 8, width of the burst length input.
- `MAX_OUTST`, 4, maximum reads in flight (power of 2, ≥1).
- `TIMEOUT_CYC`, 1024, cycles without a return before abort (only with `SDRAM_RD_TIMEOUT_EN`).

Ports:
- `iCLK` in 1: clock; all logic on rising edge.
- `iRST_n` in 1: synchronous active-low reset.
- `iBUTTON` in 1: raw active-low button.
- `iSTART` in 1: single-cycle start pulse, ORed with the button trigger.
- `address_in` in ADDR_W: start address.
- `len_in` in LEN_W: number of words to read.
- `read` out 1: read request.
- `address_out` out ADDR_W: request address.
- `waitrequest` in 1: controller stall; a request is accepted when `read && !waitrequest`.
- `readdata` in DATA_W: returned data.
- `readdatavalid` in 1: return strobe, in request order.
- `outdata` out DATA_W: last returned word.
- `outvalid` out 1: one-cycle strobe per returned word.
- `outack` out 1: one-cycle strobe at burst completion.
- `busy` out 1: high in every state other than IDLE.
- `err` out 1: sticky timeout flag, cleared by the next trigger.
- `c_state` out 3: current state encoding.

## Operation
- **Trigger**
  - `iBUTTON` passes through a 2-flop synchroniser.
  - trigger = previous synchronised value 1 and current 0, registered.
  - The trigger, or `iSTART`, is sampled only in IDLE; it is ignored while busy.
- **States**
  - IDLE(0): on trigger, latch `address_in` into `address_out` and `len_in` into a remaining-request counter, clear `err`.
    - If `len_in` = 0, go to DONE; otherwise go to ISSUE.
  - ISSUE(1): drive `read`=1.
    - On acceptance, increment `address_out` (wraps modulo 2^ADDR_W), decrement the request counter and increment the outstanding counter.
    - Deassert `read` when the request counter reaches 0, or when outstanding = MAX_OUTST and no return arrives in the same cycle.
    - When all requests are accepted, go to DRAIN.
  - DRAIN(2): `read`=0; wait until the received count equals the latched length.
  - DONE(3): pulse `outack` for 1 cycle, then go to IDLE.
  - ERR(4): pulse `outack` with `err`=1, then go to IDLE.
- **Returns** are accepted in ISSUE and DRAIN.
  - Each `readdatavalid` loads `outdata`, pulses `outvalid`, decrements outstanding and increments the received count.
  - A simultaneous accept and return leaves outstanding unchanged.
- `readdatavalid` in IDLE is ignored; `outdata` holds its value.
- **Counter widths:** request and received counters are LEN_W; the outstanding counter is clog2(MAX_OUTST)+1.
- **Reset mid-burst:** all state is abandoned and outputs return to reset values. Late returns after reset are ignored.

## Timing
- **Reset values:** `read`=0, `address_out`=0, `outdata`=0, `outvalid`=0, `outack`=0, `busy`=0, `err`=0, `c_state`=0.
- **Button path:** a falling edge on `iBUTTON` produces the trigger 3 cycles later; IDLE→ISSUE follows on the next edge.
- **`iSTART` path:** `iSTART` high in IDLE gives `read`=1 on the next cycle.
- **Throughput:** with `waitrequest`=0 and return latency L, one request is accepted per cycle. A burst of N words finishes with `outack` N+L+1 cycles after `read` first rises, provided L < MAX_OUTST.
- `outvalid` is registered one cycle after `readdatavalid`.

## Configuration
- **`SDRAM_RD_TIMEOUT_EN` defined:**
  - A watchdog counts cycles in ISSUE or DRAIN while outstanding > 0 and no return arrives; it resets on every return.
  - At TIMEOUT_CYC: set `err`, drop `read`, go to ERR.
- **Undefined:** no watchdog; `err` is tied to 0 and ERR is unreachable.

## Structure
- Package `sdram_rd_pkg`: state encoding constants (IDLE..ERR) and a `clog2` helper function.
- Sub-module `btn_edge_sync`: synchroniser plus falling-edge detector, one-cycle trigger output.

## Test plan
- **Single word:** `iSTART` with `address_in`=0x100, `len_in`=1, L=3 → one accept at 0x100; `outdata`=`readdata`, `outvalid` once, `outack` once, `busy` low afterwards.
- **Back-to-back burst:** `len_in`=8, `waitrequest`=0, L=2 → addresses 0x100–0x107 accepted on consecutive cycles, 8 `outvalid` strobes in order, `outack` 11 cycles after the first `read`.
- **Back-pressure and cap:** `waitrequest` high for 5 cycles mid-burst, L=10, MAX_OUTST=4 → `read` held with `address_out` stable; never more than 4 in flight.
- **Wrap and zero length:** `address_in`=0x1FFFFFF, `len_in`=2 → second request at 0. A start with `len_in`=0 → no `read`, `outack` 2 cycles after the start.
- **Button and reset:**
  - `iBUTTON` falls → trigger 3 cycles later.
  - A second press while busy is ignored.
  - `iRST_n` low mid-burst → all outputs return to reset values next cycle.
- **Timeout (with `SDRAM_RD_TIMEOUT_EN`):** suppress `readdatavalid` after 3 returns → `err`=1 and `outack` at TIMEOUT_CYC; the next `iSTART` clears `err`.

Source files
------------

// File: rtl/sdram_rd_pkg.sv
// Shared state encoding and elaboration helpers for the SDRAM burst read engine.
package sdram_rd_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StDrain = 3'd2,
        StDone  = 3'd3,
        StErr   = 3'd4
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for the raw active-low button plus a registered falling-edge
// detector; trig_o is a single-cycle pulse three cycles after the button falls.
module btn_edge_sync (
    input  logic iCLK,
    input  logic iRST_n,
    input  logic btn_ni,
    output logic trig_o
);
    logic sync1_q, sync2_q, prev_q, trig_q;

    // Synchroniser resets to the released level so a held-idle button never fires.
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            trig_q  <= 1'b0;
        end else begin
            sync1_q <= btn_ni;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            trig_q  <= prev_q & ~sync2_q;
        end
    end

    assign trig_o = trig_q;

endmodule

// File: rtl/sdram_burst_rd.sv
// SDRAM burst read engine: pipelined Avalon-MM single-word reads, returns streamed out.
// Define SDRAM_RD_TIMEOUT_EN to enable the watchdog abort (err / ERR state).
module sdram_burst_rd
    import sdram_rd_pkg::*;
#(
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned MAX_OUTST   = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iBUTTON,
    input  logic              iSTART,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic              read,
    output logic [ADDR_W-1:0] address_out,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata,
    input  logic              readdatavalid,
    output logic [DATA_W-1:0] outdata,
    output logic              outvalid,
    output logic              outack,
    output logic              busy,
    output logic              err,
    output logic [2:0]        c_state
);
    localparam int unsigned OUT_W = clog2(MAX_OUTST) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  req_q, req_d, len_q, len_d, rcv_q, rcv_d;
    logic [OUT_W-1:0]  outst_q, outst_d;
    logic [DATA_W-1:0] outdata_q;
    logic              outvalid_q, outack_q;
    logic              trig, start, accept, ret, wd_hit;

    btn_edge_sync u_btn (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .btn_ni (iBUTTON),
        .trig_o (trig)
    );

    assign start  = (state_q == StIdle) && (trig || iSTART);
    assign ret    = readdatavalid && ((state_q == StIssue) || (state_q == StDrain));
    // At the cap a same-cycle return frees a slot, so the request may still go out.
    assign read   = (state_q == StIssue) && (req_q != '0) && !wd_hit &&
                    !((outst_q == OUT_W'(MAX_OUTST)) && !readdatavalid);
    assign accept = read && !waitrequest;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        req_d   = req_q;
        len_d   = len_q;
        rcv_d   = rcv_q + LEN_W'(ret);
        outst_d = outst_q + OUT_W'(accept) - OUT_W'(ret);
        if (accept) begin
            addr_d = addr_q + ADDR_W'(1);
            req_d  = req_q - LEN_W'(1);
        end
        case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = address_in;
                    req_d   = len_in;
                    len_d   = len_in;
                    rcv_d   = '0;
                    outst_d = '0;
                    state_d = (len_in == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (wd_hit) begin
                    state_d = StErr;
                end else if (accept && (req_q == LEN_W'(1))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (wd_hit) begin
                    state_d = StErr;
                end else if (rcv_d == len_q) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            req_q      <= '0;
            len_q      <= '0;
            rcv_q      <= '0;
            outst_q    <= '0;
            outdata_q  <= '0;
            outvalid_q <= 1'b0;
            outack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            len_q      <= len_d;
            rcv_q      <= rcv_d;
            outst_q    <= outst_d;
            outvalid_q <= ret;
            outack_q   <= (state_q == StDone) || (state_q == StErr);
            if (ret) begin
                outdata_q <= readdata;
            end
        end
    end

`ifdef SDRAM_RD_TIMEOUT_EN
    localparam int unsigned WD_W = clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q;

    assign wd_hit = (wd_q == WD_W'(TIMEOUT_CYC));

    // Counts silent cycles while reads are owed; any return restarts the count.
    always_comb begin
        wd_d = '0;
        if (((state_q == StIssue) || (state_q == StDrain)) && (outst_q != '0) &&
            !ret && !wd_hit) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (start) begin
                err_q <= 1'b0;
            end else if (wd_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign wd_hit = 1'b0;
    assign err    = 1'b0;
`endif

    assign address_out = addr_q;
    assign outdata     = outdata_q;
    assign outvalid    = outvalid_q;
    assign outack      = outack_q;
    assign busy        = (state_q != StIdle);
    assign c_state     = state_q;

endmodule
